// File: rtl/probe_capture_pkg.sv
// -----------------------------------------------------------------------------
// probe_capture_pkg
// Shared types and helpers for the debug-probe capture sequencer.
//   cap_state_e          : controller state encoding (3 bits)
//   capture_params_legal : elaboration-time check of the DEPTH / PRE_TRIG pair
// -----------------------------------------------------------------------------
package probe_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } cap_state_e;

    // DEPTH must be a power of two in 4..1024 and the pre-trigger window
    // must leave room for at least the trigger sample itself.
    function automatic bit capture_params_legal(input int depth, input int pre_trig);
        bit pow2;
        pow2 = (depth > 32'sd0) && ((depth & (depth - 32'sd1)) == 32'sd0);
        return pow2 && (depth >= 32'sd4) && (depth <= 32'sd1024) &&
               (pre_trig >= 32'sd0) && (pre_trig < depth);
    endfunction

endpackage

// File: rtl/probe_capture_ram.sv
// -----------------------------------------------------------------------------
// probe_capture_ram
// Simple dual-port sample buffer, DATA_W x DEPTH. Synchronous write, registered
// one-cycle read. The storage array has no reset so it maps onto block RAM;
// only the read-data register is reset so the read port starts at zero.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata: write port
//   re/raddr      : read request; rdata updates on the edge that samples re
//   rdata         : registered read data (holds when re is low)
// -----------------------------------------------------------------------------
module probe_capture_ram #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_r;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rd_data_r <= mem_r[raddr];
        end
    end

    assign rdata = rd_data_r;

endmodule

// File: rtl/probe_capture_ctrl.sv
// -----------------------------------------------------------------------------
// probe_capture_ctrl
// Capture sequencer for the debug probe bus. After arm_i it fills a circular
// buffer, waits for a masked-compare trigger, keeps PRE_TRIG samples before and
// DEPTH-PRE_TRIG samples from the trigger on, then freezes the buffer and
// replays the window oldest-first through the read port.
// Optional build macro:
//   PROBE_CAPTURE_TRIG_EDGE_EN : adds trig_edge_i; when high the trigger only
//                                fires on a rising edge of the match condition.
// Ports:
//   sys_clk, sys_rst_n         : clock, asynchronous active-low reset
//   arm_i                      : start capture (IDLE/DONE only)
//   abort_i                    : return to IDLE, wins over arm_i
//   probe_i                    : sampled probe bus
//   trig_mask_i, trig_value_i  : trigger compare mask (1 = compared) and value
//   trig_edge_i                : edge-trigger select (macro builds only)
//   rd_en_i                    : read request, honoured in DONE only
//   rd_valid_o/rd_data_o/rd_last_o : read response, one cycle after rd_en_i
//   busy_o, done_o             : capture in progress / window ready
//   trig_addr_o                : buffer address holding the trigger sample
// -----------------------------------------------------------------------------
module probe_capture_ctrl
    import probe_capture_pkg::*;
#(
    parameter int DATA_W   = 20,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4,
    // Derived from DEPTH; not meant to be overridden.
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] probe_i,
    input  logic [DATA_W-1:0] trig_mask_i,
    input  logic [DATA_W-1:0] trig_value_i,
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
    input  logic              trig_edge_i,
`endif
    input  logic              rd_en_i,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] trig_addr_o
);

    if (!capture_params_legal(DEPTH, PRE_TRIG)) begin : g_param_check
        $error("probe_capture_ctrl: illegal DEPTH/PRE_TRIG combination");
    end

    localparam logic [ADDR_W-1:0] PRE_C       = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PRE_LAST_C  = ADDR_W'((PRE_TRIG > 0) ? (PRE_TRIG - 1) : 0);
    localparam logic [ADDR_W-1:0] POST_INIT_C = ADDR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] ONE_C       = ADDR_W'(1'b1);
    localparam logic [ADDR_W:0]   DEPTH_C     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_RD_C   = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   RD_ONE_C    = (ADDR_W + 1)'(1'b1);
    // With no pre-trigger window the PRETRIG phase is skipped entirely.
    localparam cap_state_e        ARM_NEXT_C  = (PRE_TRIG == 0) ? ST_WAIT_TRIG : ST_PRETRIG;

    cap_state_e        state_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] fill_cnt_r;
    logic [ADDR_W-1:0] post_cnt_r;
    logic [ADDR_W-1:0] trig_addr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   rd_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              rd_valid_r;
    logic              rd_last_r;
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
    logic              match_prev_r;
`endif

    logic              match_s;
    logic              fire_s;
    logic              we_s;
    logic              re_s;

    // Trigger compare; the edge qualifier only exists in edge-capable builds.
    always_comb begin
        match_s = (((probe_i ^ trig_value_i) & trig_mask_i) == {DATA_W{1'b0}});
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
        if (trig_edge_i) begin
            fire_s = match_s && !match_prev_r;
        end else begin
            fire_s = match_s;
        end
`else
        fire_s = match_s;
`endif
    end

    // Buffer port enables; writing and reading are tied to disjoint states.
    always_comb begin
        we_s = (state_r == ST_PRETRIG) || (state_r == ST_WAIT_TRIG) || (state_r == ST_POST);
        re_s = (state_r == ST_DONE) && rd_en_i && !abort_i && !arm_i && (rd_cnt_r != DEPTH_C);
    end

    // Capture sequencer: state, pointers, counters and registered status outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {ADDR_W{1'b0}};
            fill_cnt_r   <= {ADDR_W{1'b0}};
            post_cnt_r   <= {ADDR_W{1'b0}};
            trig_addr_r  <= {ADDR_W{1'b0}};
            rd_ptr_r     <= {ADDR_W{1'b0}};
            rd_cnt_r     <= {(ADDR_W + 1){1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_last_r    <= 1'b0;
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
            match_prev_r <= 1'b0;
`endif
        end else begin
            rd_valid_r <= re_s;
            rd_last_r  <= re_s && (rd_cnt_r == LAST_RD_C);
            if (re_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
                rd_cnt_r <= rd_cnt_r + RD_ONE_C;
            end
            if (we_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end

            if (abort_i) begin
                state_r    <= ST_IDLE;
                busy_r     <= 1'b0;
                done_r     <= 1'b0;
                rd_valid_r <= 1'b0;
                rd_last_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE, ST_DONE: begin
                        if (arm_i) begin
                            state_r      <= ARM_NEXT_C;
                            wr_ptr_r     <= {ADDR_W{1'b0}};
                            fill_cnt_r   <= {ADDR_W{1'b0}};
                            busy_r       <= 1'b1;
                            done_r       <= 1'b0;
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
                            match_prev_r <= 1'b0;
`endif
                        end
                    end
                    ST_PRETRIG: begin
                        fill_cnt_r <= fill_cnt_r + ONE_C;
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
                        match_prev_r <= 1'b0;
`endif
                        if (fill_cnt_r == PRE_LAST_C) begin
                            state_r <= ST_WAIT_TRIG;
                        end
                    end
                    ST_WAIT_TRIG: begin
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
                        match_prev_r <= match_s;
`endif
                        if (fire_s) begin
                            trig_addr_r <= wr_ptr_r;
                            post_cnt_r  <= POST_INIT_C;
                            if (POST_INIT_C == {ADDR_W{1'b0}}) begin
                                // Trigger sample is the last one of the window.
                                state_r  <= ST_DONE;
                                busy_r   <= 1'b0;
                                done_r   <= 1'b1;
                                rd_ptr_r <= wr_ptr_r - PRE_C;
                                rd_cnt_r <= {(ADDR_W + 1){1'b0}};
                            end else begin
                                state_r <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        post_cnt_r <= post_cnt_r - ONE_C;
                        if (post_cnt_r == ONE_C) begin
                            // Oldest kept sample sits PRE_TRIG slots before the trigger.
                            state_r  <= ST_DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                            rd_ptr_r <= trig_addr_r - PRE_C;
                            rd_cnt_r <= {(ADDR_W + 1){1'b0}};
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    probe_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (probe_i),
        .re    (re_s),
        .raddr (rd_ptr_r),
        .rdata (rd_data_o)
    );

    assign rd_valid_o  = rd_valid_r;
    assign rd_last_o   = rd_last_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign trig_addr_o = trig_addr_r;

endmodule

// File: tb/tb_probe_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_probe_capture_ctrl
// Two instances: dut_a with default parameters (PRE_TRIG = 4) and dut_b with
// PRE_TRIG = 0. Probe/mask/value are shared; arm/abort/read are per instance.
// The reference model records every written sample and derives the trigger
// index, completion point and readout window from the capture rules.
// -----------------------------------------------------------------------------
module tb_probe_capture_ctrl;

    localparam int DW    = 20;
    localparam int DEPTH = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          arm_a, abort_a, rd_en_a;
    logic          arm_b, abort_b, rd_en_b;
    logic [DW-1:0] probe, mask, value;
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
    logic          trig_edge;
`endif

    logic          a_valid, a_last, a_busy, a_done;
    logic [DW-1:0] a_data;
    logic [3:0]    a_taddr;
    logic          b_valid, b_last, b_busy, b_done;
    logic [DW-1:0] b_data;
    logic [3:0]    b_taddr;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] sq[$];

    always #5 sys_clk = ~sys_clk;

    probe_capture_ctrl dut_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm_i(arm_a), .abort_i(abort_a),
        .probe_i(probe), .trig_mask_i(mask), .trig_value_i(value),
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
        .trig_edge_i(trig_edge),
`endif
        .rd_en_i(rd_en_a), .rd_valid_o(a_valid), .rd_data_o(a_data), .rd_last_o(a_last),
        .busy_o(a_busy), .done_o(a_done), .trig_addr_o(a_taddr)
    );

    probe_capture_ctrl #(.PRE_TRIG(0)) dut_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm_i(arm_b), .abort_i(abort_b),
        .probe_i(probe), .trig_mask_i(mask), .trig_value_i(value),
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
        .trig_edge_i(trig_edge),
`endif
        .rd_en_i(rd_en_b), .rd_valid_o(b_valid), .rd_data_o(b_data), .rd_last_o(b_last),
        .busy_o(b_busy), .done_o(b_done), .trig_addr_o(b_taddr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_match(input logic [DW-1:0] s);
        return ((s ^ value) & mask) == 20'h00000;
    endfunction

    task automatic set_arm(input bit use_b, input logic v);
        if (use_b) arm_b = v; else arm_a = v;
    endtask

    // Arm one instance and feed probe samples until the model says the window
    // is complete or max_writes samples have been written.
    // mode 0: counter base+k; 1: random; 2: mismatch for k < pre+base, then match;
    // 3: always match.  arm_at: write index during which arm_i is pulsed (-1 none).
    task automatic capture(input bit use_b, input int pre, input int mode, input int base,
                           input int max_writes, input int arm_at, input bit edge_en,
                           output int t);
        logic [DW-1:0] p;
        sq.delete();
        t = -1;
        set_arm(use_b, 1'b1);
        @(posedge sys_clk); #1;
        set_arm(use_b, 1'b0);
        check("arm_busy", use_b ? b_busy : a_busy, 1);
        check("arm_done", use_b ? b_done : a_done, 0);
        for (int k = 0; k < max_writes; k++) begin
            case (mode)
                0: p = DW'(base + k);
                1: p = DW'($urandom);
                2: p = (k < pre + base) ? ~value : value;
                default: p = value;
            endcase
            probe = p;
            if (k == arm_at) set_arm(use_b, 1'b1);
            @(posedge sys_clk); #1;
            set_arm(use_b, 1'b0);
            sq.push_back(p);
            if (t < 0 && k >= pre && m_match(p) &&
                (!edge_en || k == pre || !m_match(sq[k-1]))) t = k;
            if (t >= 0 && k + 1 == t + DEPTH - pre) begin
                check("done", use_b ? b_done : a_done, 1);
                check("busy_at_done", use_b ? b_busy : a_busy, 0);
                check("trig_addr", use_b ? b_taddr : a_taddr, t % DEPTH);
                break;
            end else begin
                if (use_b ? (b_busy !== 1'b1 || b_done !== 1'b0) : (a_busy !== 1'b1 || a_done !== 1'b0))
                    check("busy_during", {use_b ? b_busy : a_busy, use_b ? b_done : a_done}, 2);
            end
        end
    endtask

    // Read DEPTH+1 samples back to back; the last request must be ignored.
    task automatic readout(input bit use_b, input int pre, input int t);
        if (use_b) rd_en_b = 1'b1; else rd_en_a = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            @(posedge sys_clk); #1;
            if (i < DEPTH) begin
                check("rd_valid", use_b ? b_valid : a_valid, 1);
                check("rd_data", use_b ? b_data : a_data, sq[t - pre + i]);
                check("rd_last", use_b ? b_last : a_last, (i == DEPTH - 1) ? 1 : 0);
            end else begin
                check("rd_extra", use_b ? b_valid : a_valid, 0);
            end
        end
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    initial begin
        int t;
        int pre;
        bit ub;
        sys_rst_n = 1'b0;
        {arm_a, abort_a, rd_en_a, arm_b, abort_b, rd_en_b} = 6'b000000;
        probe = 20'h00000; mask = 20'hFFFFF; value = 20'd100;
`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
        trig_edge = 1'b0;
`endif
        #23;
        check("rst_outputs_a", {a_valid, a_last, a_busy, a_done, a_taddr, a_data}, 0);
        check("rst_outputs_b", {b_valid, b_last, b_busy, b_done, b_taddr, b_data}, 0);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // Test 1: counter probe, trigger on 100 -> window 96..111.
        capture(1'b0, 4, 0, 0, 200, -1, 1'b0, t);
        check("t1_trig_found", (t >= 0) ? 1 : 0, 1);
        if (t >= 0) readout(1'b0, 4, t);

        // Test 2: PRE_TRIG = 0, value 5 -> window 5..20.
        value = 20'd5;
        capture(1'b1, 0, 0, 0, 100, -1, 1'b0, t);
        check("t2_trig_found", (t >= 0) ? 1 : 0, 1);
        if (t >= 0) readout(1'b1, 0, t);

        // Test 3: match only during PRETRIG -> never triggers; abort.
        value = 20'd2;
        capture(1'b0, 4, 0, 0, 40, -1, 1'b0, t);
        abort_a = 1'b1;
        @(posedge sys_clk); #1; abort_a = 1'b0;
        check("abort_busy", a_busy, 0);
        check("abort_done", a_done, 0);
        rd_en_a = 1'b1;
        @(posedge sys_clk); #1; rd_en_a = 1'b0;
        check("idle_read_ignored", a_valid, 0);

        // Test 4: arm+abort in IDLE stays idle; arm during POST is ignored.
        arm_a = 1'b1; abort_a = 1'b1;
        @(posedge sys_clk); #1; arm_a = 1'b0; abort_a = 1'b0;
        check("arm_abort_busy", a_busy, 0);
        @(posedge sys_clk); #1;
        check("arm_abort_busy2", a_busy, 0);
        value = 20'd100;
        capture(1'b0, 4, 0, 0, 200, 103, 1'b0, t);
        if (t >= 0) readout(1'b0, 4, t);

        // Test 5: asynchronous reset mid-POST, then a clean re-arm.
        capture(1'b0, 4, 0, 0, 105, -1, 1'b0, t);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_a", {a_valid, a_last, a_busy, a_done, a_taddr, a_data}, 0);
        @(negedge sys_clk); sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        capture(1'b0, 4, 0, 0, 200, -1, 1'b0, t);
        check("t5_trig_found", (t >= 0) ? 1 : 0, 1);
        if (t >= 0) readout(1'b0, 4, t);

        // Mask all-zero: immediate trigger on the first WAIT_TRIG cycle.
        mask = 20'h00000;
        capture(1'b0, 4, 1, 0, 100, -1, 1'b0, t);
        check("mask0_t", t, 4);
        if (t >= 0) readout(1'b0, 4, t);

        // Randomized captures on both instances.
        for (int r = 0; r < 6; r++) begin
            ub  = r[0];
            pre = ub ? 0 : 4;
            mask  = DW'((32'd1 << $urandom_range(0, 19)) | (32'd1 << $urandom_range(0, 19)) |
                        (32'd1 << $urandom_range(0, 19)));
            value = DW'($urandom);
            capture(ub, pre, 1, 0, 400, -1, 1'b0, t);
            if (t >= 0) begin
                readout(ub, pre, t);
            end else begin
                if (ub) abort_b = 1'b1; else abort_a = 1'b1;
                @(posedge sys_clk); #1; abort_a = 1'b0; abort_b = 1'b0;
            end
        end

`ifdef PROBE_CAPTURE_TRIG_EDGE_EN
        // Edge trigger: held match fires at WAIT_TRIG entry; after mismatches, on the rising edge.
        trig_edge = 1'b1;
        mask = 20'hFFFFF; value = 20'h5A5A5;
        capture(1'b0, 4, 3, 0, 100, -1, 1'b1, t);
        check("edge_held_t", t, 4);
        if (t >= 0) readout(1'b0, 4, t);
        capture(1'b0, 4, 2, 5, 100, -1, 1'b1, t);
        check("edge_rise_t", t, 9);
        if (t >= 0) readout(1'b0, 4, t);
        trig_edge = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
